// File: rtl/irq_pkg.sv
// Shared constants and helpers for the eight-source interrupt controller.
// Register offsets, source count and the HIGHEST summary bit live here.
package irq_pkg;

    localparam int NUM_IRQ           = 8;
    localparam int HIGHEST_VALID_BIT = 31;

    localparam logic [1:0] OFF_PENDING = 2'd0;
    localparam logic [1:0] OFF_ENABLE  = 2'd1;
    localparam logic [1:0] OFF_EDGE    = 2'd2;
    localparam logic [1:0] OFF_HIGHEST = 2'd3;

    typedef logic [NUM_IRQ-1:0] irq_vec_t;

    // Index of the lowest set bit; bit 0 has the highest priority.
    function automatic logic [2:0] lowest_index(input irq_vec_t vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[2:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// N-bit two-flop synchroniser with synchronous active-high reset.
// Used in front of the request lines when sources are asynchronous to clk.
module irq_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous request lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: PENDING / ENABLE / EDGE / HIGHEST registers.
// Define IRQ_SYNC_EN to insert a two-flop synchroniser on iIrqSource.
module irq_controller
    import irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFF20_0400
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [7:0]  iIrqSource,
    input  logic        iReadEnable,
    input  logic        iWriteEnable,
    input  logic [3:0]  iByteEnable,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    output logic [31:0] oReadData,
    output logic [7:0]  oPendingInterrupt
);

    irq_vec_t    src_s;
    irq_vec_t    prev_r;
    irq_vec_t    pending_r;
    irq_vec_t    enable_r;
    irq_vec_t    edge_r;
    irq_vec_t    pending_nxt_s;
    irq_vec_t    rise_s;
    irq_vec_t    clr_s;
    irq_vec_t    active_s;
    logic        sel_s;
    logic        rd_s;
    logic        wr_s;
    logic [1:0]  offset_s;
    logic [31:0] highest_s;
    logic [31:0] rdata_s;
    logic        unused_s;

`ifdef IRQ_SYNC_EN
    irq_sync #(
        .WIDTH (NUM_IRQ)
    ) u_irq_sync (
        .clk (iCLK),
        .rst (iRST),
        .d   (iIrqSource),
        .q   (src_s)
    );
`else
    assign src_s = iIrqSource;
`endif

    assign sel_s    = (iAddress[31:4] == BASE_ADDR[31:4]);
    assign offset_s = iAddress[3:2];
    assign rd_s     = iReadEnable & sel_s;
    assign wr_s     = iWriteEnable & sel_s & iByteEnable[0];
    assign active_s = pending_r & enable_r;

    assign oPendingInterrupt = active_s;

    assign unused_s = ^{iAddress[1:0], iByteEnable[3:1], iWriteData[31:8]};

    // Edge detection and W1C; a new edge in the clear cycle keeps the bit set.
    always_comb begin
        rise_s = src_s & ~prev_r;
        if (wr_s && (offset_s == OFF_PENDING)) begin
            clr_s = iWriteData[NUM_IRQ-1:0];
        end else begin
            clr_s = '0;
        end
        pending_nxt_s = (edge_r & (rise_s | (pending_r & ~clr_s)))
                      | (~edge_r & src_s);
    end

    // HIGHEST summary word built from the masked pending vector.
    always_comb begin
        highest_s                    = 32'd0;
        highest_s[HIGHEST_VALID_BIT] = |active_s;
        highest_s[2:0]               = lowest_index(active_s);
    end

    // Read mux over the four register offsets.
    always_comb begin
        case (offset_s)
            OFF_PENDING: rdata_s = {24'd0, pending_r};
            OFF_ENABLE:  rdata_s = {24'd0, enable_r};
            OFF_EDGE:    rdata_s = {24'd0, edge_r};
            OFF_HIGHEST: rdata_s = highest_s;
            default:     rdata_s = 32'd0;
        endcase
    end

    // prev tracks the sampled source even in reset so held lines give no edge.
    always_ff @(posedge iCLK) begin
        prev_r <= src_s;
    end

    // Pending, configuration registers and registered read data.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pending_r <= '0;
            enable_r  <= '0;
            edge_r    <= '1;
            oReadData <= 32'd0;
        end else begin
            pending_r <= pending_nxt_s;
            if (wr_s && (offset_s == OFF_ENABLE)) begin
                enable_r <= iWriteData[NUM_IRQ-1:0];
            end else begin
                enable_r <= enable_r;
            end
            if (wr_s && (offset_s == OFF_EDGE)) begin
                edge_r <= iWriteData[NUM_IRQ-1:0];
            end else begin
                edge_r <= edge_r;
            end
            if (rd_s) begin
                oReadData <= rdata_s;
            end else begin
                oReadData <= 32'd0;
            end
        end
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller that sits directly upstream of the CPU core and drives its 8-bit pending-interrupt input. It captures eight peripheral request lines as edge- or level-sensitive sources, latches them in a pending register, masks them with an enable register, and exposes all state as a slave on the CPU data bus. Software acknowledges edge interrupts with write-1-to-clear.

## Interface
- BASE_ADDR, 32'hFF20_0400, register-window base; must be 16-byte aligned.
- iCLK  input  1  system clock; all state changes on its rising edge.
- iRST  input  1  synchronous, active-high reset.
- iIrqSource  input  8  raw request lines; bit i is source i.
- iReadEnable  input  1  data-bus read strobe.
- iWriteEnable  input  1  data-bus write strobe.
- iByteEnable  input  4  data-bus byte lanes; only lane 0 (bits 7:0) is significant.
- iAddress  input  32  data-bus byte address.
- iWriteData  input  32  data-bus write data.
- oReadData  output  32  registered read data; 0 when not selected.
- oPendingInterrupt  output  8  pending AND enable; connects to the CPU pending-interrupt input.

## Operation
- Select: iAddress[31:4] == BASE_ADDR[31:4]; offset is iAddress[3:2]; iAddress[1:0] ignored.
- Offset 0, PENDING: read returns {24'b0, pending}. Write with lane 0 enabled clears bits where iWriteData[i]=1 and EDGE[i]=1; level bits are unaffected.
- Offset 1, ENABLE: read/write, 8 bits.
- Offset 2, EDGE: read/write, 8 bits; 1 = rising-edge source, 0 = level source.
- Offset 3, HIGHEST: read-only.
  - Bit 31 = |(pending & enable).
  - Bits 2:0 = index of the lowest set bit of pending & enable; bit 0 has highest priority.
  - All other bits 0; all bits 0 when none pending.
- Writes with lane 0 disabled, or writes to HIGHEST, have no effect.
- Sampled source s: iIrqSource, or its synchronised copy (see Configuration). prev is s registered each cycle.
- Edge bit (EDGE[i]=1): pending[i] is set when s[i]=1 and prev[i]=0.
  - Set and W1C clear in the same cycle: set wins, and the bit stays 1.
- Level bit (EDGE[i]=0): pending[i] <= s[i] every cycle.
- Changing EDGE[i] does not alter pending[i] that cycle. The new mode applies from the next cycle.
- Reset values:
  - pending = 0, ENABLE = 0, EDGE = 8'hFF, oReadData = 0, oPendingInterrupt = 0, synchroniser flops = 0.
  - While iRST=1, prev loads s, so a source already high when reset releases does not create an edge.
- Reset mid-transaction: a read or write in a reset cycle is discarded, and oReadData is 0 the following cycle.
- Simultaneous iReadEnable and iWriteEnable: the write is performed; the read returns pre-write contents.

## Timing
- Read latency 1: oReadData is valid in the cycle after the cycle with iReadEnable=1 and address selected. Otherwise it is 0 that cycle.
- Write takes effect at the rising edge of the strobe cycle and is visible to a read issued in the next cycle.
- oPendingInterrupt is combinational from the pending and ENABLE registers, with no extra delay.
- Source-to-pending latency: source high before edge N gives pending high after edge N (1 cycle). With synchroniser: 3 cycles.
- No wait states; every strobe completes in one cycle.

## Configuration
- IRQ_SYNC_EN defined: each iIrqSource bit passes through a 2-flop synchroniser (reset 0) before edge/level logic. Sources may be asynchronous. Latency +2 cycles.
- IRQ_SYNC_EN undefined: s = iIrqSource directly. Sources must be synchronous to iCLK.

## Structure
- Package irq_pkg holds the register offset constants (PENDING=0, ENABLE=1, EDGE=2, HIGHEST=3), NUM_IRQ=8, and the HIGHEST valid bit position (31).
- One sub-module, irq_sync: an N-bit 2-flop synchroniser with synchronous reset. It is instantiated only under IRQ_SYNC_EN.

## Test plan
- Reset, then read all four offsets -> 0, 0, 8'hFF, 0; oPendingInterrupt = 0.
- ENABLE=8'h05, pulse iIrqSource[2] for one cycle -> pending=8'h04 and oPendingInterrupt=8'h04 one cycle later (three with IRQ_SYNC_EN); HIGHEST reads 32'h8000_0002.
- Pending=8'h06, ENABLE=8'hFF, write PENDING=8'h02 -> pending=8'h04; then a W1C of bit 2 in the same cycle as a new edge on source 2 -> bit 2 stays 1.
- EDGE=8'hFE, hold iIrqSource[0]=1 for 5 cycles -> pending[0]=1 throughout; W1C of bit 0 has no effect; source low -> pending[0]=0 next cycle.
- Hold iIrqSource=8'h80 across reset release with ENABLE=8'h80 -> no pending[7]; falling then rising edge on source 7 -> pending[7]=1.
- Read with iAddress=BASE_ADDR+16 -> oReadData=0; write ENABLE with iByteEnable=4'b1110 -> ENABLE unchanged.
